// File: rtl/buyruk_yukleyici.sv
// rtl/buyruk_yukleyici.sv - byte-stream program loader and asynchronous-read instruction store for the RV32I core
module buyruk_yukleyici #(
   parameter int          DERINLIK = 128,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          yukle_gecerli,
   input  logic [7:0]                    yukle_bayt,
   input  logic                          yukle_son,
   output logic                          yukle_hazir,
   input  logic [31:0]                   ps,
   output logic [31:0]                   buyruk,
   output logic                          islemci_rst,
   output logic [$clog2(DERINLIK):0]     kelime_sayisi,
   output logic                          hata
);

   localparam int AW = $clog2(DERINLIK);
   localparam logic [AW:0] DOLU = (AW+1)'(DERINLIK);

   typedef enum logic [1:0] {BOS, YUKLE, CALIS} durum_t;

   durum_t       durum, durum_sonraki;
   logic [1:0]   b;
   logic [AW:0]  wp;
   logic [31:0]  kismi;
   logic [31:0]  yeni_kelime;
   logic [31:0]  bellek [DERINLIK];
   logic         aktarim;
   logic         kelime_bitti;
   logic         yaz;
   logic         getir_gecerli;

   assign yukle_hazir   = (durum != CALIS) && !rst;
   assign islemci_rst   = (durum != CALIS) || rst;
   assign kelime_sayisi = wp;
   assign aktarim       = yukle_gecerli && yukle_hazir;
   assign kelime_bitti  = (b == 2'd3) || yukle_son;
   assign yaz           = aktarim && kelime_bitti && (wp < DOLU);

   // Bytes above the current index are zero so a short last word pads cleanly.
   always_comb begin
      yeni_kelime = '0;
      for (int k = 0; k < 4; k++) begin
         if (k < int'(b))
            yeni_kelime[k*8 +: 8] = kismi[k*8 +: 8];
         else if (k == int'(b))
            yeni_kelime[k*8 +: 8] = yukle_bayt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) durum <= BOS;
      else     durum <= durum_sonraki;
   end

   always_comb begin
      durum_sonraki = durum;
      case (durum)
         BOS:     if (aktarim) durum_sonraki = yukle_son ? CALIS : YUKLE;
         YUKLE:   if (aktarim && yukle_son) durum_sonraki = CALIS;
         CALIS:   durum_sonraki = CALIS;
         default: durum_sonraki = BOS;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         b     <= 2'd0;
         wp    <= '0;
         kismi <= '0;
         hata  <= 1'b0;
      end else begin
         if (aktarim) begin
            kismi[b*8 +: 8] <= yukle_bayt;
            b               <= kelime_bitti ? 2'd0 : b + 2'd1;
            if (yaz)
               wp <= wp + 1'b1;
            if (wp == DOLU)
               hata <= 1'b1;
         end
         if (durum == CALIS && ps[1:0] != 2'b00)
            hata <= 1'b1;
      end
   end

   // The store is deliberately not reset; wp=0 hides stale contents.
   always_ff @(posedge clk) begin
      if (yaz)
         bellek[wp[AW-1:0]] <= yeni_kelime;
   end

   assign getir_gecerli = (ps[1:0] == 2'b00) &&
                          ({2'b00, ps[31:2]} < {{(31-AW){1'b0}}, wp});

   assign buyruk = (durum == CALIS && getir_gecerli) ? bellek[ps[AW+1:2]] : NOP;

endmodule

// File: tb/tb_buyruk_yukleyici.sv
// tb/tb_buyruk_yukleyici.sv - randomized self-checking bench for buyruk_yukleyici
module tb_buyruk_yukleyici;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        yg = 1'b0, ys = 1'b0;
   logic [7:0]  yb = '0;
   logic        hz, irst, hata;
   logic [31:0] ps = '0, buyruk;
   logic [7:0]  ks;
   logic        yg2 = 1'b0, ys2 = 1'b0;
   logic [7:0]  yb2 = '0;
   logic        hz2, irst2, hata2;
   logic [31:0] ps2 = '0, buyruk2;
   logic [2:0]  ks2;

   int checks = 0;
   int errors = 0;
   logic [7:0] bq[$];

   always #5 clk = ~clk;

   buyruk_yukleyici #(.DERINLIK(128), .NOP(NOP)) dut (
      .clk(clk), .rst(rst), .yukle_gecerli(yg), .yukle_bayt(yb), .yukle_son(ys),
      .yukle_hazir(hz), .ps(ps), .buyruk(buyruk), .islemci_rst(irst),
      .kelime_sayisi(ks), .hata(hata));

   buyruk_yukleyici #(.DERINLIK(4), .NOP(NOP)) dut4 (
      .clk(clk), .rst(rst), .yukle_gecerli(yg2), .yukle_bayt(yb2), .yukle_son(ys2),
      .yukle_hazir(hz2), .ps(ps2), .buyruk(buyruk2), .islemci_rst(irst2),
      .kelime_sayisi(ks2), .hata(hata2));

   // Reference: word i is bytes 4i..4i+3 of the stream, little-endian, zero-padded.
   function automatic logic [31:0] model_word(input int i);
      logic [31:0] w;
      w = '0;
      for (int k = 0; k < 4; k++)
         if (4*i + k < bq.size()) w[k*8 +: 8] = bq[4*i + k];
      return w;
   endfunction

   function automatic int model_count(input int depth);
      int n;
      n = (bq.size() + 3) / 4;
      return (n > depth) ? depth : n;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; yg = 1'b0; yg2 = 1'b0; ys = 1'b0; ys2 = 1'b0; ps = '0; ps2 = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic push(input bit sel, input logic [7:0] d, input logic son);
      int budget;
      @(negedge clk);
      if (sel) begin yg2 = 1'b1; yb2 = d; ys2 = son; end
      else     begin yg  = 1'b1; yb  = d; ys  = son; end
      budget = 0;
      while (((sel ? hz2 : hz) !== 1'b1) && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 20) begin
         checks++; errors++;
         $display("FAIL push_timeout: yukle_hazir stayed low for %0d cycles, required 1", budget);
      end
      @(posedge clk); #1;
      yg = 1'b0; ys = 1'b0; yg2 = 1'b0; ys2 = 1'b0;
   endtask

   task automatic load_queue(input int maxgap);
      for (int i = 0; i < bq.size(); i++) begin
         repeat ($urandom_range(maxgap, 0)) @(negedge clk);
         push(1'b0, bq[i], (i == bq.size() - 1));
      end
   endtask

   task automatic check_store(input string tag);
      int n;
      n = model_count(128);
      @(negedge clk);
      checks++;
      if (ks !== 8'(n)) begin
         errors++;
         $display("FAIL %s_count: kelime_sayisi got %0d, required %0d", tag, ks, n);
      end
      for (int i = 0; i <= n; i++) begin
         ps = 32'(4*i); #1;
         checks++;
         if (buyruk !== ((i < n) ? model_word(i) : NOP)) begin
            errors++;
            $display("FAIL %s_word%0d: buyruk got %h, required %h", tag, i, buyruk,
                     (i < n) ? model_word(i) : NOP);
         end
      end
      ps = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({hz, irst, hata, ks, buyruk} !== {1'b0, 1'b1, 1'b0, 8'd0, NOP}) begin
         errors++;
         $display("FAIL reset_outputs: hazir=%b irst=%b hata=%b ks=%0d buyruk=%h, required 0 1 0 0 %h",
                  hz, irst, hata, ks, buyruk, NOP);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (hz !== 1'b1 || irst !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: hazir=%b irst=%b, required 1 1", hz, irst);
      end
   endtask

   task automatic test_directed();
      logic [7:0] prog [8];
      prog = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'ha0, 8'h00};
      do_reset();
      bq.delete();
      foreach (prog[i]) bq.push_back(prog[i]);
      for (int i = 0; i < 7; i++) push(1'b0, prog[i], 1'b0);
      ps = '0; #1;
      checks++;
      if (irst !== 1'b1 || buyruk !== NOP) begin
         errors++;
         $display("FAIL directed_preload: irst=%b buyruk=%h, required 1 %h", irst, buyruk, NOP);
      end
      push(1'b0, prog[7], 1'b1);
      checks++;
      if (irst !== 1'b0 || hz !== 1'b0) begin
         errors++;
         $display("FAIL directed_calis_entry: irst=%b hazir=%b, required 0 0", irst, hz);
      end
      ps = 32'd0; #1;
      checks++;
      if (buyruk !== 32'h0050_0513) begin
         errors++; $display("FAIL directed_ps0: got %h, required 00500513", buyruk);
      end
      ps = 32'd4; #1;
      checks++;
      if (buyruk !== 32'h00a0_0593) begin
         errors++; $display("FAIL directed_ps4: got %h, required 00a00593", buyruk);
      end
      ps = 32'd8; #1;
      checks++;
      if (buyruk !== NOP || ks !== 8'd2) begin
         errors++; $display("FAIL directed_ps8: buyruk=%h ks=%0d, required %h 2", buyruk, ks, NOP);
      end
   endtask

   task automatic test_misaligned();
      @(negedge clk);
      ps = 32'd2; #1;
      checks++;
      if (buyruk !== NOP || hata !== 1'b0) begin
         errors++; $display("FAIL misaligned_fetch: buyruk=%h hata=%b, required %h 0", buyruk, hata, NOP);
      end
      @(negedge clk);
      ps = 32'd0;
      repeat (3) @(negedge clk);
      checks++;
      if (hata !== 1'b1) begin
         errors++; $display("FAIL misaligned_sticky: hata=%b, required 1", hata);
      end
      do_reset();
      checks++;
      if (hata !== 1'b0) begin
         errors++; $display("FAIL misaligned_clear: hata=%b, required 0", hata);
      end
   endtask

   task automatic test_partial();
      do_reset();
      bq.delete();
      for (int i = 1; i <= 6; i++) bq.push_back(8'(i));
      load_queue(0);
      check_store("partial");
      checks++;
      if (model_word(1) !== 32'h0000_0605) begin
         errors++; $display("FAIL partial_model: model word1 %h, required 00000605", model_word(1));
      end
   endtask

   task automatic test_random_gaps();
      int n;
      for (int t = 0; t < 6; t++) begin
         do_reset();
         bq.delete();
         n = $urandom_range(40, 1);
         for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
         load_queue((t % 2 == 0) ? 0 : 3);
         check_store($sformatf("rand%0d", t));
         @(negedge clk);
         yg = 1'b1; ys = 1'b1; yb = 8'hff;
         repeat (3) @(negedge clk);
         yg = 1'b0; ys = 1'b0;
         checks++;
         if (ks !== 8'(model_count(128)) || hz !== 1'b0 || hata !== 1'b0) begin
            errors++;
            $display("FAIL rand%0d_calis_ignore: ks=%0d hazir=%b hata=%b, required %0d 0 0",
                     t, ks, hz, hata, model_count(128));
         end
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int i = 0; i < 5; i++) push(1'b0, 8'(8'hc0 + i), 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (ks !== 8'd0 || irst !== 1'b1 || hz !== 1'b0) begin
         errors++; $display("FAIL midreset_clear: ks=%0d irst=%b hazir=%b, required 0 1 0", ks, irst, hz);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (hz !== 1'b1 || irst !== 1'b1 || ks !== 8'd0) begin
         errors++; $display("FAIL midreset_bos: hazir=%b irst=%b ks=%0d, required 1 1 0", hz, irst, ks);
      end
      bq.delete();
      for (int i = 0; i < 4; i++) bq.push_back(8'($urandom));
      load_queue(1);
      check_store("midreset");
   endtask

   task automatic test_overflow();
      do_reset();
      bq.delete();
      for (int i = 0; i < 20; i++) bq.push_back(8'($urandom));
      for (int i = 0; i < 20; i++) begin
         push(1'b1, bq[i], (i == 19));
         checks++;
         if (hata2 !== ((i + 1 >= 17) ? 1'b1 : 1'b0) || irst2 !== ((i == 19) ? 1'b0 : 1'b1)) begin
            errors++;
            $display("FAIL overflow_byte%0d: hata=%b irst=%b, required %b %b", i + 1, hata2, irst2,
                     (i + 1 >= 17), (i != 19));
         end
      end
      checks++;
      if (ks2 !== 3'(model_count(4))) begin
         errors++; $display("FAIL overflow_count: got %0d, required %0d", ks2, model_count(4));
      end
      for (int i = 0; i <= 4; i++) begin
         ps2 = 32'(4*i); #1;
         checks++;
         if (buyruk2 !== ((i < 4) ? model_word(i) : NOP)) begin
            errors++;
            $display("FAIL overflow_word%0d: got %h, required %h", i, buyruk2,
                     (i < 4) ? model_word(i) : NOP);
         end
      end
      ps2 = '0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_misaligned();
      test_partial();
      test_random_gaps();
      test_mid_reset();
      test_overflow();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
